instruction_fetch: RTL and testbench

Sequential fetch stage upstream of `instruction_decoder`. It reads the opcode byte at the program counter, computes the instruction's length, and fetches 0–2 operand bytes. It then presents the opcode, assembled operand and opcode address to the decode/execute stage through a valid/ready handshake. Control-flow redirects from execute (branch, jump, call, ret) reload the PC and abort any fetch in progress.

---
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential opcode/operand fetcher with valid/ready bundle output and PC redirect.
// Define IFETCH_HALT_STOP_EN to stop fetching after a HALT (0xF0) bundle is accepted.
module instruction_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_instr,
    output logic [15:0]           out_operand,
    output logic [1:0]            out_length,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  halted
);
    typedef enum logic [2:0] {IDLE, FETCH_OP, FETCH_B1, FETCH_B2, PRESENT, HALTED} state_t;

    state_t state, next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0] op_len;
    logic halt_stop;

    function automatic logic [1:0] instr_length(input logic [7:0] op);
        return (op == 8'h20 || (op >= 8'hF8 && op <= 8'hFA)) ? 2'd3 :
               (op == 8'h21 || op[7:4] == 4'hA || op == 8'hF1 || op == 8'hF3) ? 2'd2 : 2'd1;
    endfunction

    assign op_len    = instr_length(mem_rdata);
    assign mem_addr  = pc;
    assign mem_rd    = state == FETCH_OP || state == FETCH_B1 || state == FETCH_B2;
    assign out_valid = state == PRESENT;
`ifdef IFETCH_HALT_STOP_EN
    assign halt_stop = out_instr == 8'hF0;
    assign halted    = state == HALTED;
`else
    assign halt_stop = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:     next = FETCH_OP;
            FETCH_OP: next = mem_ready ? (op_len > 2'd1 ? FETCH_B1 : PRESENT) : FETCH_OP;
            FETCH_B1: next = mem_ready ? (out_length == 2'd3 ? FETCH_B2 : PRESENT) : FETCH_B1;
            FETCH_B2: next = mem_ready ? PRESENT : FETCH_B2;
            PRESENT:  next = out_ready ? (halt_stop ? HALTED : FETCH_OP) : PRESENT;
            HALTED:   next = HALTED;
            default:  next = IDLE;
        endcase
        if (pc_load) next = FETCH_OP;
    end

    // Operand bytes shift in low-first so a 3-byte instruction ends with {b1, b2}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VECTOR;
            out_instr   <= 8'h00;
            out_operand <= 16'h0000;
            out_length  <= 2'd1;
            out_pc      <= '0;
        end else if (pc_load) begin
            pc <= pc_load_value;
        end else if (mem_rd && mem_ready) begin
            pc <= pc + ADDR_WIDTH'(1);
            if (state == FETCH_OP) begin
                out_instr   <= mem_rdata;
                out_length  <= op_len;
                out_pc      <= pc;
                out_operand <= 16'h0000;
            end else if (state == FETCH_B1) begin
                out_operand <= {8'h00, mem_rdata};
            end else begin
                out_operand <= {out_operand[7:0], mem_rdata};
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed checks of instruction_fetch against a bundle-level model.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_instr;
    logic [15:0] out_operand;
    logic [1:0]  out_length;
    logic [15:0] out_pc;
    logic        halted;

    logic [7:0] mem [0:65535];
    assign mem_rdata = mem[mem_addr];

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_load(pc_load),
        .pc_load_value(pc_load_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_operand(out_operand), .out_length(out_length),
        .out_pc(out_pc), .halted(halted)
    );

    always #5 clk = ~clk;

`ifdef IFETCH_HALT_STOP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Model: address of the bundle being built, bytes of it captured so far.
    logic [15:0] mpc;
    int nf;
    bit idle, mhalt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_len(input logic [7:0] op);
        if (op == 8'h20 || op == 8'hF8 || op == 8'hF9 || op == 8'hFA) return 3;
        if (op == 8'h21 || (op >= 8'hA0 && op <= 8'hAF) || op == 8'hF1 || op == 8'hF3) return 2;
        return 1;
    endfunction

    function automatic logic [15:0] ref_operand(input logic [15:0] a);
        logic [15:0] a1 = a + 16'd1;
        logic [15:0] a2 = a + 16'd2;
        int l = ref_len(mem[a]);
        if (l == 1) return 16'h0000;
        if (l == 2) return {8'h00, mem[a1]};
        return {mem[a1], mem[a2]};
    endfunction

    function automatic bit exp_valid();
        return !idle && !mhalt && nf == ref_len(mem[mpc]);
    endfunction

    function automatic bit exp_rd();
        return !idle && !mhalt && nf < ref_len(mem[mpc]);
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("out_valid", out_valid, exp_valid());
        chk("mem_rd", mem_rd, exp_rd());
        chk("halted", halted, mhalt);
        if (exp_rd()) chk("mem_addr", mem_addr, 16'(mpc + nf));
        if (exp_valid()) begin
            chk("out_instr", out_instr, mem[mpc]);
            chk("out_length", out_length, ref_len(mem[mpc]));
            chk("out_operand", out_operand, ref_operand(mpc));
            chk("out_pc", out_pc, mpc);
        end
    endtask

    task automatic drive(input bit pl, input logic [15:0] plv, input bit mr, input bit ordy);
        bit ev = exp_valid();
        bit er = exp_rd();
        pc_load = pl; pc_load_value = plv; mem_ready = mr; out_ready = ordy;
        if (pl) begin
            mpc = plv; nf = 0; idle = 0; mhalt = 0;
        end else if (idle) begin
            idle = 0;
        end else if (er && mr) begin
            nf++;
        end else if (ev && ordy) begin
            if (HALT_EN && mem[mpc] == 8'hF0) mhalt = 1;
            mpc = mpc + 16'(ref_len(mem[mpc]));
            nf = 0;
        end
    endtask

    task automatic run_until_valid(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (out_valid) return;
            drive(0, 16'h0, 1, 1);
        end
        chk("valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_load = 0; mem_ready = 0; out_ready = 0;
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_operand", out_operand, 0);
        chk("rst_out_length", out_length, 1);
        chk("rst_out_pc", out_pc, 0);
        mpc = 16'h0000; nf = 0; idle = 1; mhalt = 0;
        rst_n = 1'b1;
        drive(0, 16'h0, 1, 1);
    endtask

    initial begin
        int lat, waits;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h10; mem[16'h0001] = 8'h55;
        mem[16'h0005] = 8'hF0;
        mem[16'h0040] = 8'h20; mem[16'h0041] = 8'h12; mem[16'h0042] = 8'h34;
        mem[16'h0080] = 8'hA3; mem[16'h0081] = 8'hA7;
        mem[16'h00C0] = 8'hF8;
        mem[16'hFFFF] = 8'hF9;
        do_reset();

        tick();
        chk("c1_mem_rd", mem_rd, 1);
        chk("c1_mem_addr", mem_addr, 16'h0000);
        drive(0, 16'h0, 1, 1);
        tick();
        chk("c2_valid", out_valid, 1);
        chk("c2_instr", out_instr, 8'h10);
        chk("c2_len", out_length, 1);
        chk("c2_operand", out_operand, 16'h0000);
        chk("c2_pc", out_pc, 16'h0000);
        drive(0, 16'h0, 1, 1);
        tick();
        chk("c3_next_addr", mem_addr, 16'h0001);

        drive(1, 16'h0040, 1, 1);
        run_until_valid(10);
        chk("l3_instr", out_instr, 8'h20);
        chk("l3_operand", out_operand, 16'h1234);
        chk("l3_len", out_length, 3);
        chk("l3_pc", out_pc, 16'h0040);
        drive(0, 16'h0, 1, 1);
        tick();
        chk("l3_next_addr", mem_addr, 16'h0043);

        drive(1, 16'h0080, 1, 1);
        lat = 0; waits = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (out_valid) break;
            if (mem_addr == 16'h0081 && waits < 3) begin
                waits++;
                drive(0, 16'h0, 0, 0);
            end else begin
                drive(0, 16'h0, 1, 0);
            end
        end
        chk("stall_latency", lat, 6);
        for (int i = 0; i < 5; i++) begin
            drive(0, 16'h0, 1, 0);
            tick();
            chk("stall_operand", out_operand, 16'h00A7);
        end
        drive(0, 16'h0, 1, 1);

        tick();
        drive(1, 16'h00C0, 1, 1);
        tick();
        drive(0, 16'h0, 1, 1);
        tick();
        chk("b1_addr", mem_addr, 16'h00C1);
        drive(1, 16'h0100, 1, 1);
        tick();
        chk("redirect_addr", mem_addr, 16'h0100);
        chk("redirect_valid", out_valid, 0);
        drive(0, 16'h0, 1, 1);

        tick();
        drive(1, 16'hFFFF, 1, 1);
        run_until_valid(10);
        chk("wrap_operand", out_operand, 16'h1055);
        chk("wrap_pc", out_pc, 16'hFFFF);
        drive(0, 16'h0, 1, 1);
        tick();
        chk("wrap_next_addr", mem_addr, 16'h0002);

        drive(1, 16'h0005, 1, 1);
        run_until_valid(10);
        chk("halt_instr", out_instr, 8'hF0);
        drive(0, 16'h0, 1, 1);
        tick();
        if (HALT_EN) begin
            chk("halt_flag", halted, 1);
            for (int i = 0; i < 5; i++) begin
                drive(0, 16'h0, 1, 1);
                tick();
                chk("halt_no_rd", mem_rd, 0);
            end
            drive(1, 16'h0000, 1, 1);
            tick();
            chk("halt_cleared", halted, 0);
            chk("halt_resume_addr", mem_addr, 16'h0000);
        end else begin
            chk("no_halt_addr", mem_addr, 16'h0006);
            chk("no_halt_flag", halted, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 39) == 0, 16'($urandom), $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 7);
            tick();
        end

        drive(1, 16'h0040, 1, 0);
        run_until_valid(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_addr", mem_addr, 16'h0000);
        chk("async_rst_len", out_length, 1);
        do_reset();
        tick();
        chk("post_rst_addr", mem_addr, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
